seq_multi_func_alu: RTL and testbench

- Parametrised, handshaked successor of the board-level multi-function ALU.
- Operand width is set by WIDTH. Operands and opcode are taken in through a valid/ready input handshake. The result and flags are registered and returned through a valid/ready output handshake.
- Logic ops, add/sub and SLTU finish in one cycle. Shift-left and multiply are iterative, multi-cycle operations.
- Sits between the operand-select logic and the display/result path, and replaces the purely combinational ALU.

---
 rtl/seq_multi_func_alu.sv | 163 ++++++++++++++++
 tb/tb_seq_multi_func_alu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multi_func_alu.sv
// Handshaked multi-function ALU: single-cycle logic/add/sub/sltu, iterative SLL and MUL.
// Define SEQ_MULTI_FUNC_ALU_MUL_EN to build the shift-add multiplier (opcode 1000); otherwise 1000 is illegal.
module seq_multi_func_alu #(
  parameter int WIDTH = 32
) (
  input  logic             SALU_clk,
  input  logic             SALU_rst,
  input  logic             SALU_in_valid,
  output logic             SALU_in_ready,
  input  logic [3:0]       SALU_op,
  input  logic [WIDTH-1:0] SALU_data_A,
  input  logic [WIDTH-1:0] SALU_data_B,
  output logic             SALU_out_valid,
  input  logic             SALU_out_ready,
  output logic [WIDTH-1:0] SALU_result,
  output logic             SALU_zero_flag,
  output logic             SALU_carry_flag,
  output logic             SALU_overflow_flag,
  output logic             SALU_illegal_flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Input side is ready only in IDLE; output side is valid only in DONE and pops on out_ready.
  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q, start_cnt;
  logic [WIDTH-1:0] result_q, res_d;
  logic             zero_q, carry_q, ovf_q, ill_q;
  logic             zero_d, carry_d, ovf_d, ill_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
`ifdef SEQ_MULTI_FUNC_ALU_MUL_EN
  logic [WIDTH-1:0] acc_q;
`endif

  always_comb begin
    start_cnt = '0;
    if (SALU_op == OP_SLL) start_cnt = {1'b0, SALU_data_A[SHW-1:0]};
`ifdef SEQ_MULTI_FUNC_ALU_MUL_EN
    if (SALU_op == OP_MUL) start_cnt = CW'(WIDTH);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (SALU_in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (SALU_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result and flags of the latched operation; sampled when the counter has run out.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    case (op_q)
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_NOR:  res_d = ~(a_q | b_q);
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff;
        carry_d = a_q < b_q;
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_SLL:  res_d = b_q;
`ifdef SEQ_MULTI_FUNC_ALU_MUL_EN
      OP_MUL:  res_d = acc_q;
`endif
      default: ill_d = 1'b1;
    endcase
    zero_d = !ill_d && (res_d == '0);
  end

  always_ff @(posedge SALU_clk) begin
    if (SALU_rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifdef SEQ_MULTI_FUNC_ALU_MUL_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (SALU_in_valid) begin
          op_q  <= SALU_op;
          a_q   <= SALU_data_A;
          b_q   <= SALU_data_B;
          cnt_q <= start_cnt;
`ifdef SEQ_MULTI_FUNC_ALU_MUL_EN
          acc_q <= '0;
`endif
        end
        BUSY: if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
          // SLL shifts B in place; MUL walks B as multiplier while A doubles as multiplicand.
          if (op_q == OP_SLL) begin
            b_q <= b_q << 1;
          end
`ifdef SEQ_MULTI_FUNC_ALU_MUL_EN
          else if (op_q == OP_MUL) begin
            if (b_q[0]) acc_q <= acc_q + a_q;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end
`endif
        end else begin
          result_q <= res_d;
          zero_q   <= zero_d;
          carry_q  <= carry_d;
          ovf_q    <= ovf_d;
          ill_q    <= ill_d;
        end
        default: ;
      endcase
    end
  end

  assign SALU_in_ready      = (state_q == IDLE);
  assign SALU_out_valid     = (state_q == DONE);
  assign SALU_result        = result_q;
  assign SALU_zero_flag     = zero_q;
  assign SALU_carry_flag    = carry_q;
  assign SALU_overflow_flag = ovf_q;
  assign SALU_illegal_flag  = ill_q;

endmodule

// File: tb/tb_seq_multi_func_alu.sv
// Bench for seq_multi_func_alu (WIDTH=32): directed table, backpressure/reset sequences, random vs model.
module tb_seq_multi_func_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero_f, carry_f, ovf_f, ill_f;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z, c, ov, il;
    int          lat;
  } vec_t;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  seq_multi_func_alu #(.WIDTH(32)) dut (
    .SALU_clk(clk), .SALU_rst(rst),
    .SALU_in_valid(in_valid), .SALU_in_ready(in_ready),
    .SALU_op(op), .SALU_data_A(data_a), .SALU_data_B(data_b),
    .SALU_out_valid(out_valid), .SALU_out_ready(out_ready),
    .SALU_result(result), .SALU_zero_flag(zero_f), .SALU_carry_flag(carry_f),
    .SALU_overflow_flag(ovf_f), .SALU_illegal_flag(ill_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic z, input logic c,
                              input logic ov, input logic il, input int lat);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.res = r; v.z = z; v.c = c; v.ov = ov; v.il = il; v.lat = lat;
    return v;
  endfunction

  // Reference: arithmetic straight from the opcode definitions.
  function automatic vec_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    longint sa, sb, s;
    logic [32:0] u;
    logic [63:0] p;
    v = mk(o, a, b, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      4'd0: v.res = a & b;
      4'd1: v.res = a | b;
      4'd2: v.res = a ^ b;
      4'd3: v.res = ~(a | b);
      4'd4: begin
        u = {1'b0, a} + {1'b0, b};
        v.res = u[31:0]; v.c = u[32];
        s = sa + sb; v.ov = (s > MAXS) || (s < MINS);
      end
      4'd5: begin
        v.res = a - b; v.c = (a < b);
        s = sa - sb; v.ov = (s > MAXS) || (s < MINS);
      end
      4'd6: v.res = (a < b) ? 32'd1 : 32'd0;
      4'd7: begin
        v.res = b << a[4:0];
        v.lat = int'(a[4:0]) + 1;
      end
`ifdef SEQ_MULTI_FUNC_ALU_MUL_EN
      4'd8: begin
        p = {32'h0, a} * {32'h0, b};
        v.res = p[31:0]; v.lat = 33;
      end
`endif
      default: v.il = 1'b1;
    endcase
    v.z = !v.il && (v.res == 32'h0);
    return v;
  endfunction

  // Called at #1 after a rising edge with the DUT idle; returns at #1 after the edge that raised out_valid.
  task automatic run_op(input vec_t v, output int lat, output logic ready_in_busy);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; op = v.op; data_a = v.a; data_b = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    ready_in_busy = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_in_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) check("out_valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_vec(input string tag, input vec_t e, input int lat, input logic rib);
    logic [31:0] exp_res;
    exp_res = exp_q.pop_front();
    check({tag, "_result"}, result, exp_res);
    check({tag, "_flags"}, {zero_f, carry_f, ovf_f, ill_f}, {e.z, e.c, e.ov, e.il});
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_busy_ready"}, rib, 1'b0);
    @(posedge clk); #1;
    check({tag, "_pop"}, {out_valid, in_ready}, 2'b01);
  endtask

  vec_t tbl[18];
  vec_t e;
  int   lat;
  logic rib;

  initial begin
    tbl[0]  = mk(4'd4, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0, 1);
    tbl[1]  = mk(4'd5, 32'h0000_0003, 32'h0000_0607, 32'hFFFF_F9FC, 0, 1, 0, 0, 1);
    tbl[2]  = mk(4'd5, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 0, 0, 0, 1);
    tbl[3]  = mk(4'd7, 32'h0000_0004, 32'h0000_0607, 32'h0000_6070, 0, 0, 0, 0, 5);
    tbl[4]  = mk(4'd7, 32'h0000_0020, 32'h0000_0607, 32'h0000_0607, 0, 0, 0, 0, 1);
    tbl[5]  = mk(4'd0, 32'h1234_5678, 32'h3333_2222, 32'h1230_0220, 0, 0, 0, 0, 1);
    tbl[6]  = mk(4'd1, 32'h0F0F_0000, 32'h00F0_F0F0, 32'h0FFF_F0F0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(4'd2, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 0, 0, 0, 0, 1);
    tbl[8]  = mk(4'd3, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
    tbl[9]  = mk(4'd3, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1, 0, 0, 0, 1);
    tbl[10] = mk(4'd6, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 0, 0, 0, 0, 1);
    tbl[11] = mk(4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0, 0, 1);
    tbl[12] = mk(4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0, 1);
    tbl[13] = mk(4'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 1, 0, 1);
    tbl[14] = mk(4'd7, 32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0000, 0, 0, 0, 0, 32);
`ifdef SEQ_MULTI_FUNC_ALU_MUL_EN
    tbl[15] = mk(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 33);
    tbl[16] = mk(4'd8, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 0, 0, 0, 33);
`else
    tbl[15] = mk(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 0, 1, 1);
    tbl[16] = mk(4'd8, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, 0, 0, 1, 1);
`endif
    tbl[17] = mk(4'd9, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 0, 0, 0, 1, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {in_ready, out_valid, zero_f, carry_f, ovf_f, ill_f}, 6'b100000);
    check("reset_result", result, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      exp_q.push_back(tbl[i].res);
      run_op(tbl[i], lat, rib);
      check_vec($sformatf("vec%0d", i), tbl[i], lat, rib);
    end

    // Backpressure: result held, second request ignored until after the pop
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd0; data_a = 32'h1234_5678; data_b = 32'h3333_2222;
    @(posedge clk); #1;
    op = 4'd2; data_a = 32'hFFFF_FFFF; data_b = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", {out_valid, in_ready}, 2'b10);
      check("bp_hold_result", result, 32'h1230_0220);
      @(posedge clk); #1;
    end
    check("bp_before_pop", result, 32'h1230_0220);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_pop", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_accepted", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_second_result", result, 32'hF0F0_F0F0);
    @(posedge clk); #1;

    // Reset in the 10th BUSY cycle of a MUL
    in_valid = 1'b1; op = 4'd8; data_a = 32'h0001_2345; data_b = 32'h0000_6789;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
`ifdef SEQ_MULTI_FUNC_ALU_MUL_EN
    check("mul_busy_before_reset", {in_ready, out_valid}, 2'b00);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_abort_ctrl", {out_valid, in_ready}, 2'b01);
    check("reset_abort_result", result, 32'h0);
    check("reset_abort_flags", {zero_f, carry_f, ovf_f, ill_f}, 4'b0000);
    rst = 1'b0;
    @(posedge clk); #1;
    e = model(4'hF, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    exp_q.push_back(e.res);
    run_op(e, lat, rib);
    check_vec("illegal_after_reset", e, lat, rib);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      e = model(4'($urandom_range(0, 15)), $urandom, (i % 7 == 0) ? 32'h0 : $urandom);
      exp_q.push_back(e.res);
      run_op(e, lat, rib);
      check_vec($sformatf("rand%0d_op%0d", i, e.op), e, lat, rib);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
